ifm_rx_ingress: RTL and testbench

IFM_RX_INGRESS -- requirements
Module: ifm_rx_ingress

---
 rtl/ifm_pkg.sv | 29 ++
 rtl/ifm_popcnt.sv | 17 +
 rtl/ifm_rx_ingress.sv | 134 +++++++++++++
 tb/tb_ifm_rx_ingress.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifm_pkg.sv
// Shared definitions for the IFM receive path: FSM state encoding and the
// per-frame info descriptor layout.
package ifm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_DROP  = 2'd2,
    ST_TRUNC = 2'd3
  } ifm_state_e;

  localparam int unsigned INFO_W         = 32;
  localparam int unsigned INFO_TUSER_BIT = 0;
  localparam int unsigned INFO_TRUNC_BIT = 1;
  localparam int unsigned INFO_LEN_LSB   = 8;
  localparam int unsigned INFO_LEN_W     = 16;

  function automatic logic [INFO_W-1:0] make_info(input logic                  tuser,
                                                  input logic                  trunc,
                                                  input logic [INFO_LEN_W-1:0] len);
    logic [INFO_W-1:0] w;
    w                                = '0;
    w[INFO_TUSER_BIT]                = tuser;
    w[INFO_TRUNC_BIT]                = trunc;
    w[INFO_LEN_LSB +: INFO_LEN_W]    = len;
    return w;
  endfunction

endpackage

// File: rtl/ifm_popcnt.sv
// Combinational byte count of a tkeep vector.
module ifm_popcnt #(
  parameter  int unsigned W  = 8,
  localparam int unsigned CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  keep,
  output logic [CW-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < W; i++) begin
      cnt = cnt + CW'(keep[i]);
    end
  end

endmodule

// File: rtl/ifm_rx_ingress.sv
// MAC receive ingress: admits whole frames into the data/info FIFOs, drops
// frames that start while the FIFOs are nearly full and truncates oversize ones.
module ifm_rx_ingress
  import ifm_pkg::*;
#(
  parameter  int C_DATA_WIDTH = 64,
  parameter  int C_MAX_LEN    = 9600,
  localparam int C_KEEP_WIDTH = C_DATA_WIDTH / 8
) (
  input  logic                               rx_clk,
  input  logic                               s2mm_resetn,
  input  logic [C_DATA_WIDTH-1:0]            rx_axis_mac_tdata,
  input  logic [C_KEEP_WIDTH-1:0]            rx_axis_mac_tkeep,
  input  logic                               rx_axis_mac_tlast,
  input  logic                               rx_axis_mac_tuser,
  input  logic                               rx_axis_mac_tvalid,
  output logic                               rx_axis_mac_tready,
  output logic [C_DATA_WIDTH+C_KEEP_WIDTH:0] data_fifo_wdata,
  output logic                               data_fifo_wren,
  input  logic                               data_fifo_afull,
  output logic [INFO_W-1:0]                  info_fifo_wdata,
  output logic                               info_fifo_wren,
  input  logic                               info_fifo_afull,
  input  logic                               cnt_clr,
  output logic [31:0]                        drop_cnt,
  output logic [31:0]                        trunc_cnt,
  output logic [3:0]                         ifm_rx_dbg
);

  localparam int unsigned CW = $clog2(C_KEEP_WIDTH + 1);

  ifm_state_e      state, nxt;
  logic [15:0]     byte_cnt, len_nxt;
  logic [CW-1:0]   beat_bytes;
  logic [16:0]     cur_len;
  logic            at_max, full;
  logic            wr_d, wr_i, last_o, trunc_o, drop_inc, trunc_inc;

  ifm_popcnt #(.W(C_KEEP_WIDTH)) u_popcnt (
    .keep (rx_axis_mac_tkeep),
    .cnt  (beat_bytes)
  );

  assign rx_axis_mac_tready = 1'b1;
  assign ifm_rx_dbg         = {2'b00, state};
  assign full               = data_fifo_afull | info_fifo_afull;

  // A frame always starts from zero in IDLE, so the stored count is only used mid-frame.
  assign cur_len = {1'b0, (state == ST_IDLE) ? 16'd0 : byte_cnt} + 17'(beat_bytes);
  assign at_max  = cur_len >= 17'(C_MAX_LEN);

  always_comb begin
    nxt       = state;
    len_nxt   = byte_cnt;
    wr_d      = 1'b0;
    wr_i      = 1'b0;
    last_o    = rx_axis_mac_tlast;
    trunc_o   = 1'b0;
    drop_inc  = 1'b0;
    trunc_inc = 1'b0;
    if (rx_axis_mac_tvalid) begin
      case (state)
        ST_IDLE: begin
          if (full) begin
            drop_inc = 1'b1;
            if (!rx_axis_mac_tlast) nxt = ST_DROP;
          end else begin
            wr_d = 1'b1;
            if (rx_axis_mac_tlast) begin
              wr_i    = 1'b1;
              len_nxt = '0;
            end else begin
              nxt     = ST_PASS;
              len_nxt = cur_len[15:0];
            end
          end
        end
        ST_PASS: begin
          wr_d = 1'b1;
          if (rx_axis_mac_tlast) begin
            wr_i    = 1'b1;
            nxt     = ST_IDLE;
            len_nxt = '0;
          end else if (at_max) begin
            last_o    = 1'b1;
            wr_i      = 1'b1;
            trunc_o   = 1'b1;
            trunc_inc = 1'b1;
            nxt       = ST_TRUNC;
            len_nxt   = '0;
          end else begin
            len_nxt = cur_len[15:0];
          end
        end
        default: begin
          if (rx_axis_mac_tlast) nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge rx_clk or negedge s2mm_resetn) begin
    if (!s2mm_resetn) begin
      state          <= ST_IDLE;
      byte_cnt       <= '0;
      data_fifo_wren <= 1'b0;
      info_fifo_wren <= 1'b0;
    end else begin
      state          <= nxt;
      byte_cnt       <= len_nxt;
      data_fifo_wren <= wr_d;
      info_fifo_wren <= wr_i;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (wr_d) data_fifo_wdata <= {last_o, rx_axis_mac_tkeep, rx_axis_mac_tdata};
    if (wr_i) info_fifo_wdata <= make_info(rx_axis_mac_tuser & ~trunc_o, trunc_o, cur_len[15:0]);
  end

  always_ff @(posedge rx_clk or negedge s2mm_resetn) begin
    if (!s2mm_resetn) begin
      drop_cnt  <= '0;
      trunc_cnt <= '0;
    end else if (cnt_clr) begin
      drop_cnt  <= '0;
      trunc_cnt <= '0;
    end else begin
      if (drop_inc && drop_cnt != '1)   drop_cnt  <= drop_cnt + 32'd1;
      if (trunc_inc && trunc_cnt != '1) trunc_cnt <= trunc_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_ifm_rx_ingress.sv
// Randomised and directed bench for ifm_rx_ingress with a frame-level reference model.
module tb_ifm_rx_ingress;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int ML = 128;

  logic          rx_clk = 1'b0;
  logic          s2mm_resetn;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic          tlast, tuser, tvalid, tready;
  logic [DW+KW:0] dwdata;
  logic          dwren, d_af;
  logic [31:0]   iwdata;
  logic          iwren, i_af, cnt_clr;
  logic [31:0]   drop_cnt, trunc_cnt;
  logic [3:0]    dbg;

  always #5 rx_clk = ~rx_clk;

  ifm_rx_ingress #(.C_DATA_WIDTH(DW), .C_MAX_LEN(ML)) dut (
    .rx_clk             (rx_clk),
    .s2mm_resetn        (s2mm_resetn),
    .rx_axis_mac_tdata  (tdata),
    .rx_axis_mac_tkeep  (tkeep),
    .rx_axis_mac_tlast  (tlast),
    .rx_axis_mac_tuser  (tuser),
    .rx_axis_mac_tvalid (tvalid),
    .rx_axis_mac_tready (tready),
    .data_fifo_wdata    (dwdata),
    .data_fifo_wren     (dwren),
    .data_fifo_afull    (d_af),
    .info_fifo_wdata    (iwdata),
    .info_fifo_wren     (iwren),
    .info_fifo_afull    (i_af),
    .cnt_clr            (cnt_clr),
    .drop_cnt           (drop_cnt),
    .trunc_cnt          (trunc_cnt),
    .ifm_rx_dbg         (dbg)
  );

  int passed = 0;
  int total  = 0;

  // Frame-level model: whether a frame is open, and why the rest of a frame is being skipped.
  bit          in_frame = 0;
  int          skip     = 0;
  int unsigned len      = 0;
  logic          e_dwren = 0, e_iwren = 0;
  logic [DW+KW:0] e_dwdata = '0;
  logic [31:0]   e_iwdata = '0, e_drop = '0, e_trunc = '0;
  logic [3:0]    e_dbg = '0;

  int unsigned   n_dwr = 0, n_iwr = 0;
  logic [DW+KW:0] obs_data = '0;
  logic [31:0]   obs_info = '0;

  logic nrst = 0, nd_af = 0, ni_af = 0, ncl = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic compare();
    chk("tready", tready, 1'b1);
    chk("data_wren", dwren, e_dwren);
    if (e_dwren) chk("data_wdata", dwdata, e_dwdata);
    chk("info_wren", iwren, e_iwren);
    if (e_iwren) chk("info_wdata", iwdata, e_iwdata);
    chk("drop_cnt", drop_cnt, e_drop);
    chk("trunc_cnt", trunc_cnt, e_trunc);
    chk("dbg", dbg, e_dbg);
    if (dwren === 1'b1) begin n_dwr++; obs_data = dwdata; end
    if (iwren === 1'b1) begin n_iwr++; obs_info = iwdata; end
  endtask

  task automatic model_step();
    int unsigned bytes;
    e_dwren = 0;
    e_iwren = 0;
    if (!s2mm_resetn) begin
      in_frame = 0; skip = 0; len = 0;
      e_drop = '0; e_trunc = '0; e_dbg = '0;
      return;
    end
    if (tvalid) begin
      bytes = $countones(tkeep);
      if (in_frame) begin
        len += bytes;
        e_dwren  = 1;
        e_dwdata = {tlast, tkeep, tdata};
        if (tlast) begin
          e_iwren  = 1;
          e_iwdata = {8'h00, len[15:0], 7'h00, tuser};
          in_frame = 0;
        end else if (len >= ML) begin
          e_dwdata[DW+KW] = 1'b1;
          e_iwren  = 1;
          e_iwdata = {8'h00, len[15:0], 8'h02};
          in_frame = 0;
          skip     = 3;
          if (e_trunc != '1) e_trunc++;
        end
      end else if (skip != 0) begin
        if (tlast) skip = 0;
      end else if (d_af || i_af) begin
        if (e_drop != '1) e_drop++;
        if (!tlast) skip = 2;
      end else begin
        len      = bytes;
        e_dwren  = 1;
        e_dwdata = {tlast, tkeep, tdata};
        if (tlast) begin
          e_iwren  = 1;
          e_iwdata = {8'h00, len[15:0], 7'h00, tuser};
        end else in_frame = 1;
      end
    end
    if (cnt_clr) begin e_drop = '0; e_trunc = '0; end
    e_dbg = in_frame ? 4'd1 : 4'(skip);
  endtask

  task automatic cycle(input bit v, input bit l, input logic [7:0] k, input bit u);
    @(negedge rx_clk);
    compare();
    s2mm_resetn = nrst;
    d_af    = nd_af;
    i_af    = ni_af;
    cnt_clr = ncl;
    tvalid  = v;
    tlast   = l;
    tkeep   = k;
    tuser   = u;
    tdata   = {$urandom, $urandom};
    model_step();
  endtask

  function automatic logic [7:0] keep_of(input int n);
    logic [15:0] t;
    t = (16'h1 << n) - 16'h1;
    return t[7:0];
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, 0);
  endtask

  task automatic send_frame(input int n, input int lb, input bit u, input int af_from, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        while ($urandom_range(0, 3) == 0) begin
          nd_af = ($urandom_range(0, 9) == 0);
          ni_af = ($urandom_range(0, 9) == 0);
          cycle(0, 0, 8'h00, 0);
        end
        nd_af = ($urandom_range(0, 9) == 0);
        ni_af = ($urandom_range(0, 9) == 0);
        ncl   = ($urandom_range(0, 49) == 0);
      end else nd_af = (i >= af_from);
      cycle(1, i == n - 1, (i == n - 1) ? keep_of(lb) : 8'hFF, u);
    end
    nd_af = 0; ni_af = 0; ncl = 0;
  endtask

  initial begin
    int unsigned b, bi;
    s2mm_resetn = 0; d_af = 0; i_af = 0; cnt_clr = 0;
    tvalid = 0; tlast = 0; tkeep = '0; tuser = 0; tdata = '0;
    nrst = 0;
    idle(3);
    nrst = 1;
    idle(2);
    chk("reset_drop_cnt", drop_cnt, 32'd0);
    chk("reset_state", dbg, 4'd0);

    // 3-beat frame, 20 bytes
    b = n_dwr;
    send_frame(3, 4, 1, 99, 0);
    idle(2);
    chk("f3_writes", n_dwr - b, 3);
    chk("f3_info", obs_info, 32'h0000_1401);
    chk("f3_tlast", obs_data[72], 1'b1);

    // frame starting under afull is dropped whole
    b = n_dwr; bi = n_iwr;
    send_frame(4, 8, 1, 0, 0);
    idle(2);
    chk("drop_writes", n_dwr - b, 0);
    chk("drop_info", n_iwr - bi, 0);
    chk("drop_cnt_1", drop_cnt, 32'd1);
    b = n_dwr;
    send_frame(4, 8, 1, 99, 0);
    idle(2);
    chk("after_drop_writes", n_dwr - b, 4);
    chk("after_drop_info", obs_info, 32'h0000_2001);

    // single-beat frame from IDLE
    b = n_dwr;
    send_frame(1, 1, 0, 99, 0);
    idle(2);
    chk("single_writes", n_dwr - b, 1);
    chk("single_info", obs_info, 32'h0000_0100);
    chk("single_state", dbg, 4'd0);

    // oversize frame truncated at 128 bytes
    b = n_dwr;
    send_frame(20, 8, 1, 99, 0);
    idle(2);
    chk("trunc_writes", n_dwr - b, 16);
    chk("trunc_info", obs_info, 32'h0000_8002);
    chk("trunc_cnt_1", trunc_cnt, 32'd1);
    chk("trunc_forced_last", obs_data[72], 1'b1);

    // afull rising mid-frame is ignored
    b = n_dwr; bi = n_iwr;
    send_frame(5, 8, 1, 1, 0);
    idle(2);
    chk("afull_mid_writes", n_dwr - b, 5);
    chk("afull_mid_info", n_iwr - bi, 1);
    chk("afull_mid_infow", obs_info, 32'h0000_2801);

    // clear beats a same-cycle drop increment
    nd_af = 1; ncl = 1;
    cycle(1, 1, 8'hFF, 0);
    nd_af = 0; ncl = 0;
    idle(2);
    chk("clr_wins_drop", drop_cnt, 32'd0);
    chk("clr_trunc", trunc_cnt, 32'd0);

    // reset in the middle of a frame; the tail becomes a new frame
    cycle(1, 0, 8'hFF, 0);
    cycle(1, 0, 8'hFF, 0);
    nrst = 0;
    cycle(1, 0, 8'hFF, 0);
    #1;
    chk("rst_dwren", dwren, 1'b0);
    chk("rst_iwren", iwren, 1'b0);
    chk("rst_state", dbg, 4'd0);
    chk("rst_tready", tready, 1'b1);
    idle(1);
    nrst = 1;
    b = n_dwr;
    cycle(1, 0, 8'hFF, 1);
    cycle(1, 1, 8'h0F, 1);
    idle(2);
    chk("frag_writes", n_dwr - b, 2);
    chk("frag_info", obs_info, 32'h0000_0C01);

    // randomised traffic
    for (int f = 0; f < 150; f++) begin
      if ($urandom_range(0, 39) == 0) begin
        nrst = 0;
        idle(1);
        nrst = 1;
      end
      send_frame($urandom_range(1, 22), $urandom_range(1, 8), 1'($urandom_range(0, 1)), 0, 1);
    end
    idle(3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
